// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-to-serial frame transmitter (start, LSB-first data, stop)
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             tx,
    output logic             busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             bit_done;

    assign bit_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (valid_in && ready_q) begin
                    shreg_d = data_in;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode the next state so they register on the same edge as the transition.
    always_comb begin
        tx_d    = 1'b1;
        busy_d  = 1'b1;
        ready_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Datapath needs no reset: IDLE reloads everything before it is used.
    always_ff @(posedge clk) begin
        cnt_q   <= cnt_d;
        idx_q   <= idx_d;
        shreg_q <= shreg_d;
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign ready_out = ready_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - self-checking bench for serial_tx
module tb_serial_tx;

    localparam int W    = 8;
    localparam int CPB  = 4;
    localparam int MAXW = 200;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         valid_in = 1'b0;
    logic         ready_out, tx, busy;

    logic         m_data = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_ready, m_tx, m_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int prev_acc = 0;

    serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .tx(tx), .busy(busy)
    );

    serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut_min (
        .clk(clk), .rst(rst), .data_in(m_data), .valid_in(m_valid),
        .ready_out(m_ready), .tx(m_tx), .busy(m_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line-level model: each accepted word becomes a queue of per-cycle tx levels.
    bit   frame_q[$];
    logic exp_tx = 1'b1, exp_busy = 1'b0, exp_ready = 1'b1;
    bit   mv = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            frame_q.delete();
            exp_tx    <= 1'b1;
            exp_busy  <= 1'b0;
            exp_ready <= 1'b1;
            mv        <= 1'b1;
        end else if (frame_q.size() > 0) begin
            exp_tx    <= frame_q.pop_front();
            exp_busy  <= 1'b1;
            exp_ready <= 1'b0;
        end else if (exp_ready && valid_in && mv) begin
            for (int c = 0; c < CPB; c++) frame_q.push_back(1'b0);
            for (int b = 0; b < W; b++)
                for (int c = 0; c < CPB; c++) frame_q.push_back(data_in[b]);
            for (int c = 0; c < CPB; c++) frame_q.push_back(1'b1);
            exp_tx    <= frame_q.pop_front();
            exp_busy  <= 1'b1;
            exp_ready <= 1'b0;
        end else begin
            exp_tx    <= 1'b1;
            exp_busy  <= 1'b0;
            exp_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("tx", {31'd0, tx}, {31'd0, exp_tx});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("ready_out", {31'd0, ready_out}, {31'd0, exp_ready});
        end
    end

    // Loopback receiver: samples mid-bit and matches words against the send order.
    logic [W-1:0] sent_q[$];
    logic [W-1:0] rx_word = '0;
    bit           rx_act = 1'b0;
    int           rx_t = 0;

    always @(negedge clk) begin
        if (!rst) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act <= 1'b1;
                rx_t   <= 1;
            end
        end else begin
            rx_t <= rx_t + 1;
            if (rx_t % CPB == CPB / 2) begin
                if (rx_t / CPB >= 1 && rx_t / CPB <= W) begin
                    rx_word[rx_t/CPB-1] <= tx;
                end else if (rx_t / CPB == W + 1) begin
                    chk("rx_stop", {31'd0, tx}, 32'd1);
                    if (sent_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_extra got %0h expected no word", rx_word);
                    end else begin
                        chk("rx_word", {24'd0, rx_word}, {24'd0, sent_q.pop_front()});
                    end
                    rx_act <= 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] w);
        int t;
        sent_q.push_back(w);
        data_in  = w;
        valid_in = 1'b1;
        t = 0;
        while (ready_out !== 1'b1 && t < MAXW) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", {31'd0, (t >= MAXW)}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        prev_acc = last_acc;
        last_acc = cyc;
    endtask

    logic lev[10];
    logic mw[2];
    logic [W-1:0] rw;
    int bc, gap, t;

    initial begin
        lev = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        mw  = '{1'b1, 1'b0};

        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", {31'd0, tx}, 32'd1);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_ready", {31'd0, ready_out}, 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rel_tx", {31'd0, tx}, 32'd1);
        chk("rel_busy", {31'd0, busy}, 32'd0);
        chk("rel_ready", {31'd0, ready_out}, 32'd1);

        for (int i = 0; i < 2; i++) begin
            chk("min_ready_pre", {31'd0, m_ready}, 32'd1);
            m_data  = mw[i];
            m_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            m_valid = 1'b0;
            chk("min_start", {29'd0, m_tx, m_busy, m_ready}, 32'b010);
            @(negedge clk);
            chk("min_data", {29'd0, m_tx, m_busy, m_ready}, {29'd0, mw[i], 2'b10});
            @(negedge clk);
            chk("min_stop", {29'd0, m_tx, m_busy, m_ready}, 32'b110);
            @(negedge clk);
            chk("min_idle", {29'd0, m_tx, m_busy, m_ready}, 32'b101);
        end

        send(8'hA5);
        bc = 0;
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < CPB; c++) begin
                chk("a5_level", {31'd0, tx}, {31'd0, lev[j]});
                if (busy) bc++;
                @(negedge clk);
            end
        end
        chk("a5_busy_cycles", bc, 40);
        chk("a5_ready_back", {31'd0, ready_out}, 32'd1);

        send(8'h00);
        send(8'hFF);
        chk("b2b_spacing", last_acc - prev_acc, 41);

        send(8'h96);
        repeat (10) @(negedge clk);
        send(8'h69);
        chk("held_spacing", last_acc - prev_acc, 41);

        send(8'h3C);
        repeat (17) @(negedge clk);
        rst = 1'b0;
        void'(sent_q.pop_back());
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, ready_out}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            rw = W'($urandom);
            send(rw);
        end

        t = 0;
        while (sent_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", sent_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial frame transmitter for the storage/sequencing library. It accepts a WIDTH-bit word over a valid/ready handshake, latches it into an internal shift register, and drives it onto a single serial line. The frame is a start bit (0), then the data bits LSB-first, then a stop bit (1), each held for CLKS_PER_BIT clocks. It is the sending end of the single-line serial link whose receiving end samples the line into flip-flops; a matching receiver instance is its reference model in verification.

## Interface
- WIDTH, default 8: data bits per frame; legal range ≥1.
- CLKS_PER_BIT, default 4: clock cycles each serial bit is held; legal range ≥1.

- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-low: sampled at the rising edge of clk; 0 resets.
- data_in  input  WIDTH  word to send; sampled only on the accept edge.
- valid_in  input  1  data_in holds a word to send.
- ready_out  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (start, data or stop bit).

## Operation
- All outputs are registered. There is no combinational path from any input to any output.
- Reset: when rst=0 at a clock edge, the next state is IDLE, with tx=1, ready_out=1 and busy=0. This applies from any state. A frame in progress is abandoned and is not resumed.
- The shift register and counters are don't-care after reset. Only the state and the outputs are reset.
- Accept: at a rising edge where state=IDLE, valid_in=1 and ready_out=1, data_in is latched into the shift register. The state moves to START.
- If valid_in=1 while not in IDLE, the word is ignored. The source must hold it until accepted.
- States and transitions:
  - IDLE: tx=1, ready_out=1, busy=0. On accept, go to START.
  - START: tx=0, ready_out=0, busy=1. Hold for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift_reg[0], ready_out=0, busy=1. Hold each bit for CLKS_PER_BIT cycles, then shift right by one and increment the bit index. After bit WIDTH-1 completes, go to STOP.
  - STOP: tx=1, ready_out=0, busy=1. Hold for CLKS_PER_BIT cycles, then go to IDLE.
- Cycle counter:
  - Width is max(1, clog2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and clears to 0 on every bit boundary.
  - With CLKS_PER_BIT=1, every state lasts exactly one cycle per bit.
- Bit index:
  - Width is max(1, clog2(WIDTH)).
  - Counts 0..WIDTH-1.
  - With WIDTH=1, DATA lasts exactly one bit.
- data_in changes after acceptance have no effect on the frame in flight.
- Undefined (X/Z) on valid_in while in IDLE and out of reset is a bench error, not a design requirement.

## Timing
- Accept happens at edge E. Output changes for the frame then follow this schedule:
  - From edge E: ready_out=0, busy=1, tx=0 (start bit).
  - From edge E+CLKS_PER_BIT: tx=data bit 0.
  - Data bit k is driven from edge E+(k+1)·CLKS_PER_BIT.
  - From edge E+(WIDTH+1)·CLKS_PER_BIT: tx=1 (stop bit).
  - From edge E+(WIDTH+2)·CLKS_PER_BIT: IDLE, ready_out=1, busy=0.
- Frame length is exactly (WIDTH+2)·CLKS_PER_BIT cycles of busy=1.
- Back-to-back:
  - If valid_in=1 on the first IDLE cycle, the next accept happens on that edge.
  - The minimum inter-frame spacing is therefore (WIDTH+2)·CLKS_PER_BIT+1 edges.
  - This gives exactly one cycle of IDLE tx=1 between frames, in addition to the stop bit.
- Reset asserted mid-frame takes effect at the same edge: from that edge, tx=1 and ready_out=1 once rst returns high. While rst=0, all outputs hold their reset values.
- Reset deasserted and valid_in=1 on the same edge: no accept on that edge. Accept is possible from the next edge.

## Test plan
- **Reset values:** hold rst=0 for 3 cycles, then release → tx=1, ready_out=1, busy=0 on every cycle, including the first after release.
- **Single frame:** WIDTH=8, CLKS_PER_BIT=4; send 8'hA5 → tx holds each level for exactly 4 cycles in the sequence 0,1,0,1,0,0,1,0,1,1; busy is high for 40 cycles; ready_out returns to 1 on cycle 40 after accept.
- **Back-to-back:** send 8'h00, then 8'hFF with valid_in held high → the second accept happens on the first IDLE cycle; tx shows a stop bit of 4 cycles plus 1 idle cycle high, then the start bit. A loopback receiver recovers 00, FF.
- **Mid-frame reset and held data:** assert rst=0 during data bit 3 of 8'h3C → tx=1 and busy=0 from that edge. Separately, change data_in during a frame → the in-flight frame is unchanged, and the new word waits for ready_out.
- **Minimum parameters:** WIDTH=1, CLKS_PER_BIT=1; send 1'b1 → tx sequence 0,1,1 over 3 cycles, then ready_out=1.
- **Random soak:** 1000 random words with random valid_in gaps, checked against a serial receiver model → every word is received in order, with no drops or duplicates.
